// File: rtl/otter_lsu.sv
// Load/store unit between the OTTER MEM stage and data port 2 of the dual-port memory.
// Define LSU_SPLIT_MISALIGNED_EN to split misaligned non-MMIO half/word accesses into byte accesses.
module otter_lsu #(
  parameter logic [31:0] IO_BASE = 32'h1100_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LSU_REQ,
  input  logic        LSU_WE,
  input  logic [31:0] LSU_ADDR,
  input  logic [31:0] LSU_WDATA,
  input  logic [1:0]  LSU_SIZE,
  input  logic        LSU_SIGN,
  output logic        LSU_READY,
  output logic        LSU_DONE,
  output logic [31:0] LSU_RDATA,
  output logic        LSU_ERR,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        MEM_WRITE2,
  output logic        MEM_READ2,
  output logic [1:0]  MEM_SIZE,
  output logic        MEM_SIGN,
  input  logic [31:0] MEM_DOUT2
);

`ifdef LSU_SPLIT_MISALIGNED_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;
  state_t state, state_nx;

  logic        we_q, sign_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        accept, misal, mmio, req_err, last_byte;
  logic [31:0] load_val;

  assign accept  = LSU_REQ && (state == IDLE);
  assign misal   = (LSU_SIZE == 2'd1 && LSU_ADDR[0]) ||
                   (LSU_SIZE == 2'd2 && LSU_ADDR[1:0] != 2'd0);
  assign mmio    = (LSU_ADDR >= IO_BASE);
  assign req_err = (LSU_SIZE == 2'd3) || (misal && (mmio || !SPLIT_EN));

`ifdef LSU_SPLIT_MISALIGNED_EN
  logic        split_q, step;
  logic [1:0]  cnt_q;
  logic [31:0] asm_q, asm_nx;

  assign last_byte = !split_q || (cnt_q == ((size_q == 2'd2) ? 2'd3 : 2'd1));
  // advance to the next byte after a store write or after a load data cycle
  assign step = !last_byte && ((state == ACC && we_q) || state == WAIT);

  always_comb begin
    asm_nx = asm_q;
    asm_nx[{cnt_q, 3'b000} +: 8] = MEM_DOUT2[7:0];
    load_val = asm_nx;
    if (!split_q)
      load_val = MEM_DOUT2;
    else if (size_q == 2'd1)
      load_val = {sign_q ? 16'h0000 : {16{asm_nx[15]}}, asm_nx[15:0]};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      split_q <= 1'b0;
      cnt_q   <= 2'd0;
      asm_q   <= 32'd0;
    end else begin
      if (accept && !req_err) begin
        split_q <= misal;
        cnt_q   <= 2'd0;
      end else if (step) begin
        cnt_q <= cnt_q + 2'd1;
      end
      if (state == WAIT) asm_q <= asm_nx;
    end
  end

  assign MEM_ADDR2 = addr_q + {30'd0, split_q ? cnt_q : 2'd0};
  assign MEM_DIN2  = split_q ? {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]} : wdata_q;
  assign MEM_SIZE  = split_q ? 2'd0 : size_q;
  assign MEM_SIGN  = split_q || sign_q;
`else
  assign last_byte = 1'b1;
  assign load_val  = MEM_DOUT2;
  assign MEM_ADDR2 = addr_q;
  assign MEM_DIN2  = wdata_q;
  assign MEM_SIZE  = size_q;
  assign MEM_SIGN  = sign_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    LSU_READY  = 1'b0;
    LSU_DONE   = 1'b0;
    LSU_ERR    = 1'b0;
    MEM_WRITE2 = 1'b0;
    MEM_READ2  = 1'b0;
    case (state)
      IDLE: begin
        LSU_READY = 1'b1;
        if (LSU_REQ) state_nx = req_err ? DONE : ACC;
      end
      ACC: begin
        MEM_WRITE2 = we_q;
        MEM_READ2  = !we_q;
        if (!we_q)         state_nx = WAIT;
        else if (last_byte) state_nx = DONE;
      end
      WAIT:    state_nx = last_byte ? DONE : ACC;
      DONE: begin
        LSU_DONE = 1'b1;
        LSU_ERR  = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // rejected requests leave the memory-side registers untouched so MEM_* keep their last value
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      if (accept) begin
        err_q <= req_err;
        if (!req_err) begin
          we_q    <= LSU_WE;
          sign_q  <= LSU_SIGN;
          size_q  <= LSU_SIZE;
          addr_q  <= LSU_ADDR;
          wdata_q <= LSU_WDATA;
        end
      end
      if (state == WAIT && last_byte) rdata_q <= load_val;
    end
  end

  assign LSU_RDATA = rdata_q;

endmodule
